// File: rtl/fmadd_add_normalize.sv
// rtl/fmadd_add_normalize.sv - FMADD add/normalize stage with iterative 1-bit normalizer
module fmadd_add_normalize #(
   parameter int MAN = 22,
   parameter int EXP = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*MAN+3:0] in_mantissa_a,
   input  logic [2*MAN+3:0] in_mantissa_b,
   input  logic [EXP:0]     in_exp,
   input  logic             in_guard,
   input  logic             in_round,
   input  logic             in_sticky,
   input  logic             in_sign,
   input  logic             in_eff_sub,
   input  logic             in_eff_add,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*MAN+3:0] out_mantissa,
   output logic [EXP:0]     out_exp,
   output logic             out_guard,
   output logic             out_round,
   output logic             out_sticky,
   output logic             out_sign,
   output logic             out_zero,
   output logic             out_overflow
);

   localparam int RW    = 2*MAN+8;
   localparam int CARRY = RW-1;
   localparam int LEAD  = RW-2;

   typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   r_q, b_q;
   logic [EXP:0]    e_q;
   logic            st_q, sign_q, eff_add_q, eff_sub_q, zero_q, ovf_q;

   logic            r_is_zero, carry, lead, e_gt1, e_inc_max;
   logic [EXP:0]    e_inc;

   assign r_is_zero = (r_q == '0);
   assign carry     = r_q[CARRY];
   assign lead      = r_q[LEAD];
   assign e_inc     = e_q + 1'b1;
   assign e_inc_max = &e_inc;
   assign e_gt1     = (e_q > (EXP+1)'(1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = ADD;
         ADD:  state_d = NORM;
         NORM: begin
            if (r_is_zero)           state_d = DONE;
            else if (carry)          state_d = e_inc_max ? DONE : NORM;
            else if (!lead && e_gt1) state_d = NORM;
            else                     state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= '0;
         b_q       <= '0;
         e_q       <= '0;
         st_q      <= 1'b0;
         sign_q    <= 1'b0;
         eff_add_q <= 1'b0;
         eff_sub_q <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               // r_q holds A during ADD and becomes the working register afterwards
               r_q       <= {1'b0, in_mantissa_a, 3'b000};
               b_q       <= {1'b0, in_mantissa_b, in_guard, in_round, in_sticky};
               e_q       <= in_exp;
               sign_q    <= in_sign;
               eff_add_q <= in_eff_add;
               eff_sub_q <= in_eff_sub;
               st_q      <= 1'b0;
               zero_q    <= 1'b0;
               ovf_q     <= 1'b0;
            end
            ADD: begin
               if (eff_add_q)      r_q <= r_q + b_q;
               else if (eff_sub_q) r_q <= (r_q >= b_q) ? (r_q - b_q) : (b_q - r_q);
            end
            NORM: begin
               if (r_is_zero) begin
                  zero_q <= 1'b1;
                  e_q    <= '0;
                  sign_q <= 1'b0;
               end else if (carry) begin
                  r_q  <= r_q >> 1;
                  st_q <= st_q | r_q[0];
                  e_q  <= e_inc;
                  if (e_inc_max) ovf_q <= 1'b1;
               end else if (!lead) begin
                  if (e_gt1) begin
                     r_q <= r_q << 1;
                     e_q <= e_q - 1'b1;
                  end else begin
                     e_q <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Result outputs are forced to zero outside DONE so idle/reset state is clean
   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign out_mantissa = out_valid ? r_q[LEAD:3] : '0;
   assign out_exp      = out_valid ? e_q : '0;
   assign out_guard    = out_valid & r_q[2];
   assign out_round    = out_valid & r_q[1];
   assign out_sticky   = out_valid & (r_q[0] | st_q);
   assign out_sign     = out_valid & sign_q;
   assign out_zero     = out_valid & zero_q;
   assign out_overflow = out_valid & ovf_q;

endmodule

// File: tb/tb_fmadd_add_normalize.sv
// tb/tb_fmadd_add_normalize.sv - scoreboard bench for fmadd_add_normalize
module tb_fmadd_add_normalize;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [47:0] in_mantissa_a, in_mantissa_b, out_mantissa;
   logic [7:0]  in_exp, out_exp;
   logic        in_guard, in_round, in_sticky, in_sign, in_eff_sub, in_eff_add;
   logic        out_guard, out_round, out_sticky, out_sign, out_zero, out_overflow;

   fmadd_add_normalize dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mantissa_a(in_mantissa_a), .in_mantissa_b(in_mantissa_b), .in_exp(in_exp),
      .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
      .in_sign(in_sign), .in_eff_sub(in_eff_sub), .in_eff_add(in_eff_add),
      .out_valid(out_valid), .out_ready(out_ready), .out_mantissa(out_mantissa),
      .out_exp(out_exp), .out_guard(out_guard), .out_round(out_round),
      .out_sticky(out_sticky), .out_sign(out_sign), .out_zero(out_zero),
      .out_overflow(out_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] mant;
      logic [7:0]  exp;
      logic        g, r, s, sign, zero, ovf;
      int          ncyc;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   bp_mode = 2;
   bit   seen_first = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: whole-value arithmetic, then closed-form shift amount from leading-zero count
   function automatic exp_t model(input logic [47:0] a, input logic [47:0] b, input logic [7:0] e,
                                  input logic g, input logic r, input logic s, input logic sign,
                                  input logic add, input logic sub);
      logic [51:0] va, vb, v;
      int ee, lz, k;
      logic st;
      exp_t x;
      va = {1'b0, a, 3'b000};
      vb = {1'b0, b, g, r, s};
      if (add)      v = va + vb;
      else if (sub) v = (va > vb) ? va - vb : vb - va;
      else          v = va;
      ee = e; st = 1'b0;
      x.sign = sign; x.zero = 1'b0; x.ovf = 1'b0; x.acc = 0; x.ncyc = 1;
      if (v == 0) begin
         x.zero = 1'b1; x.sign = 1'b0; x.exp = 8'h00; x.mant = '0;
         x.g = 1'b0; x.r = 1'b0; x.s = 1'b0;
         return x;
      end
      if (v[51]) begin
         st = v[0];
         v = v >> 1;
         ee = ee + 1;
         x.ncyc = (ee == 255) ? 1 : 2;
         x.ovf = (ee == 255);
      end else begin
         lz = 0;
         while (lz < 51 && v[50-lz] == 1'b0) lz++;
         if (lz == 0) x.ncyc = 1;
         else if (ee > 1) begin
            k = (lz < ee - 1) ? lz : ee - 1;
            v = v << k;
            ee = ee - k;
            if (k < lz) ee = 0;
            x.ncyc = k + 1;
         end else begin
            ee = 0;
            x.ncyc = 1;
         end
      end
      x.exp = 8'(ee);
      x.mant = v[50:3];
      x.g = v[2]; x.r = v[1]; x.s = v[0] | st;
      return x;
   endfunction

   task automatic issue(input logic [47:0] a, input logic [47:0] b, input logic [7:0] e,
                        input logic g, input logic r, input logic s, input logic sign,
                        input logic add, input logic sub);
      exp_t x;
      int t;
      @(posedge clk); #2;
      in_mantissa_a = a; in_mantissa_b = b; in_exp = e;
      in_guard = g; in_round = r; in_sticky = s; in_sign = sign;
      in_eff_add = add; in_eff_sub = sub; in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 300) begin
            chk("accept_timeout", t, 0);
            break;
         end
      end
      x = model(a, b, e, g, r, s, sign, add, sub);
      x.acc = cycle + 1;
      sb.push_back(x);
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_mantissa_a = 48'($urandom); in_eff_add = 1'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (bp_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            chk("in_ready_busy", in_ready, 0);
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
               x = sb[0];
               chk("mantissa", out_mantissa, x.mant);
               chk("exp", out_exp, x.exp);
               chk("guard", out_guard, x.g);
               chk("round", out_round, x.r);
               chk("sticky", out_sticky, x.s);
               chk("sign", out_sign, x.sign);
               chk("zero", out_zero, x.zero);
               chk("overflow", out_overflow, x.ovf);
               if (!seen_first) begin
                  chk("latency", cycle, x.acc + 1 + x.ncyc);
                  seen_first = 1;
               end
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen_first = 0;
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] a, b;
      int mode, t;
      rst = 1'b1; in_valid = 1'b0;
      in_mantissa_a = '0; in_mantissa_b = '0; in_exp = '0;
      in_guard = 0; in_round = 0; in_sticky = 0; in_sign = 0; in_eff_sub = 0; in_eff_add = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_mantissa", out_mantissa, 0);
      chk("reset_exp", out_exp, 0);
      @(posedge clk); #2 rst = 1'b0;

      bp_mode = 2;
      issue(48'h8000_0000_0000, 48'h8000_0000_0000, 8'h80, 0, 0, 0, 0, 1, 0);
      issue(48'hC000_0000_0000, 48'hC000_0000_0000, 8'h90, 0, 0, 0, 1, 0, 1);
      issue(48'h8000_0000_0000, 48'h4000_0000_0000, 8'h7F, 0, 0, 0, 1, 0, 1);
      issue(48'h8000_0000_0000, 48'h8000_0000_0000, 8'hFE, 0, 0, 0, 0, 1, 0);
      issue(48'h0000_0000_0003, 48'h0000_0000_0001, 8'h02, 0, 0, 0, 0, 0, 1);
      issue(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 8'h10, 1, 1, 1, 0, 1, 0);
      issue(48'h0000_0000_0001, 48'h0, 8'h00, 0, 0, 0, 1, 0, 0);
      drain();

      bp_mode = 1;
      issue(48'h9000_0000_0000, 48'h1234_5678_9ABC, 8'h40, 1, 0, 1, 1, 0, 1);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      bp_mode = 2;
      drain();

      @(posedge clk); #2;
      in_mantissa_a = 48'h1; in_mantissa_b = 48'h0; in_exp = 8'hFE;
      in_eff_add = 0; in_eff_sub = 0; in_sign = 1; in_valid = 1'b1;
      @(posedge clk); #2 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midnorm_rst_in_ready", in_ready, 1);
      chk("midnorm_rst_out_valid", out_valid, 0);
      chk("midnorm_rst_mantissa", out_mantissa, 0);
      chk("midnorm_rst_flags", {out_exp, out_guard, out_round, out_sticky, out_sign, out_zero, out_overflow}, 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (70) @(negedge clk);

      bp_mode = 0;
      for (int i = 0; i < 150; i++) begin
         a = {$urandom, $urandom} >> $urandom_range(0, 47);
         b = {$urandom, $urandom} >> $urandom_range(0, 47);
         mode = $urandom_range(0, 3);
         if (mode == 3) b = a;
         issue(a, b, 8'($urandom_range(0, 254)), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), mode == 0, mode != 0 && mode != 2);
      end
      drain();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
